// File: rtl/decode_ctrl_fsm.sv
// rtl/decode_ctrl_fsm.sv - multicycle instruction sequencing FSM with Moore control outputs
module decode_ctrl_fsm #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       dmem_wr,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       pc_src,
  output logic [3:0] state_out,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_IF_WAIT = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_I  = 4'd4,
    S_ADDR    = 4'd5,
    S_LD_WAIT = 4'd6,
    S_LD_WB   = 4'd7,
    S_ST      = 4'd8,
    S_ALU_WB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_LUI     = 4'd11,
    S_JAL     = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  // Registered control word; br_eq/br_ne arm the branch so the taken decision
  // can follow alu_zero during the BRANCH cycle itself.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       dmem_wr;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] wb_sel;
    logic       pc_src;
    logic       br_eq;
    logic       br_ne;
  } ctrl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // Counter preload: a wait state lasts MEM_WAIT cycles, counting down to 0.
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_illegal;
  ctrl_t      r_ctrl;

  state_t     w_next;
  logic [2:0] w_cnt_next;
  logic       w_f3_alu_ok;
  logic       w_br_taken;

  // ALU selector for register-register operations.
  function automatic logic [2:0] alu_r_op(input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  alu_r_op = f7 ? ALU_SUB : ALU_ADD;
      3'b111:  alu_r_op = ALU_AND;
      3'b100:  alu_r_op = ALU_XOR;
      default: alu_r_op = ALU_PASS;
    endcase
  endfunction

  // ALU selector for register-immediate operations (no subtract form).
  function automatic logic [2:0] alu_i_op(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_i_op = ALU_ADD;
      3'b111:  alu_i_op = ALU_AND;
      3'b100:  alu_i_op = ALU_XOR;
      default: alu_i_op = ALU_PASS;
    endcase
  endfunction

  // Moore control word for the state being entered; cnt is the counter value
  // that accompanies it, so the last wait cycle of fetch can be flagged.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] cnt,
                                    input logic [2:0] f3, input logic f7);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_ADD;
      end
      S_IF_WAIT: begin
        // Keep PC+4 on the ALU output so the final wait cycle can load it.
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_ADD;
        c.ir_write  = (cnt == 3'd0);
        c.pc_write  = (cnt == 3'd0);
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = alu_r_op(f3, f7);
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = alu_i_op(f3);
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_ALU;
      end
      S_ADDR, S_LD_WAIT: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_LD_WB: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_MEM;
      end
      S_ST: begin
        c.dmem_wr = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_SUB;
        c.br_eq     = (f3 == 3'b000);
        c.br_ne     = (f3 == 3'b001);
      end
      S_LUI: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_IMM;
      end
      S_JAL: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_PC4;
        c.pc_write  = 1'b1;
        c.pc_src    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign w_f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b100);

  // Next-state and wait-counter selection.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = 3'd0;
    case (r_state)
      S_FETCH: begin
        w_next     = S_IF_WAIT;
        w_cnt_next = WAIT_INIT;
      end
      S_IF_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next = S_DECODE;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               w_next = S_EXEC_R;
          OP_I:               w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = S_ADDR;
          OP_BRANCH:          w_next = S_BRANCH;
          OP_LUI:             w_next = S_LUI;
          OP_JAL:             w_next = S_JAL;
          default:            w_next = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        w_next = w_f3_alu_ok ? S_ALU_WB : S_TRAP;
      end
      S_ADDR: begin
        if (funct3 != 3'b011) begin
          w_next = S_TRAP;
        end else if (opcode == OP_LOAD) begin
          w_next     = S_LD_WAIT;
          w_cnt_next = WAIT_INIT;
        end else begin
          w_next = S_ST;
        end
      end
      S_LD_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next = S_LD_WB;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_BRANCH: begin
        w_next = ((funct3 == 3'b000) || (funct3 == 3'b001)) ? S_FETCH : S_TRAP;
      end
      S_ALU_WB, S_LD_WB, S_ST, S_LUI, S_JAL: begin
        w_next = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // State, counter, sticky illegal flag and registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_cnt     <= 3'd0;
      r_illegal <= 1'b0;
      r_ctrl    <= ctrl_of(S_FETCH, 3'd0, 3'b000, 1'b0);
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_illegal <= r_illegal | (w_next == S_TRAP);
      r_ctrl    <= ctrl_of(w_next, w_cnt_next, funct3, funct7_5);
    end
  end

  // Branch outcome is the only output that follows an input within the state.
  assign w_br_taken = (r_ctrl.br_eq & alu_zero) | (r_ctrl.br_ne & ~alu_zero);

  assign pc_write  = r_ctrl.pc_write | w_br_taken;
  assign pc_src    = r_ctrl.pc_src | w_br_taken;
  assign ir_write  = r_ctrl.ir_write;
  assign dmem_wr   = r_ctrl.dmem_wr;
  assign reg_write = r_ctrl.reg_write;
  assign alu_src_a = r_ctrl.alu_src_a;
  assign alu_src_b = r_ctrl.alu_src_b;
  assign alu_op    = r_ctrl.alu_op;
  assign wb_sel    = r_ctrl.wb_sel;
  assign state_out = r_state;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_ctrl_fsm.sv
// tb/tb_decode_ctrl_fsm.sv - self-checking bench for decode_ctrl_fsm at MEM_WAIT 1 and 3
module tb_decode_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       dw;
    logic       rw;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic [1:0] wb;
    logic       ps;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic [6:0] opc   [2];
  logic [2:0] f3    [2];
  logic       f7    [2];
  logic       zero  [2];
  logic       pcw   [2];
  logic       irw   [2];
  logic       dw    [2];
  logic       rw    [2];
  logic       sa    [2];
  logic [1:0] sb    [2];
  logic [2:0] aop   [2];
  logic [1:0] wb    [2];
  logic       ps    [2];
  logic [3:0] st    [2];
  logic       ill   [2];

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  decode_ctrl_fsm #(.MEM_WAIT(1)) u_dut_w1 (
    .clk(clk), .rst(rst_n[0]), .opcode(opc[0]), .funct3(f3[0]), .funct7_5(f7[0]),
    .alu_zero(zero[0]), .pc_write(pcw[0]), .ir_write(irw[0]), .dmem_wr(dw[0]),
    .reg_write(rw[0]), .alu_src_a(sa[0]), .alu_src_b(sb[0]), .alu_op(aop[0]),
    .wb_sel(wb[0]), .pc_src(ps[0]), .state_out(st[0]), .illegal(ill[0])
  );

  decode_ctrl_fsm #(.MEM_WAIT(3)) u_dut_w3 (
    .clk(clk), .rst(rst_n[1]), .opcode(opc[1]), .funct3(f3[1]), .funct7_5(f7[1]),
    .alu_zero(zero[1]), .pc_write(pcw[1]), .ir_write(irw[1]), .dmem_wr(dw[1]),
    .reg_write(rw[1]), .alu_src_a(sa[1]), .alu_src_b(sb[1]), .alu_op(aop[1]),
    .wb_sel(wb[1]), .pc_src(ps[1]), .state_out(st[1]), .illegal(ill[1])
  );

  function automatic int mw_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic exp_t observe(input int d);
    exp_t e;
    e.st = st[d]; e.pcw = pcw[d]; e.irw = irw[d]; e.dw = dw[d]; e.rw = rw[d];
    e.sa = sa[d]; e.sb = sb[d]; e.op = aop[d]; e.wb = wb[d]; e.ps = ps[d]; e.ill = ill[d];
    return e;
  endfunction

  function automatic exp_t ent(input logic [3:0] s, input logic a, input logic [1:0] b,
                               input logic [2:0] o);
    exp_t e;
    e = '0;
    e.st = s; e.sa = a; e.sb = b; e.op = o;
    return e;
  endfunction

  // Expected per-cycle outputs for one instruction, starting in FETCH.
  task automatic build(input int mw, input logic [6:0] o, input logic [2:0] fn3,
                       input logic fn7, input logic z, output bit trapped);
    exp_t e;
    logic [2:0] op;
    bit tr;
    bit taken;
    tr = 1'b0;
    exp_q.delete();
    exp_q.push_back(ent(4'd0, 1'b0, 2'b01, 3'b001));
    for (int i = 0; i < mw; i++) begin
      e = ent(4'd1, 1'b0, 2'b01, 3'b001);
      if (i == mw - 1) begin e.pcw = 1'b1; e.irw = 1'b1; end
      exp_q.push_back(e);
    end
    exp_q.push_back(ent(4'd2, 1'b0, 2'b00, 3'b000));
    case (o)
      7'b0110011, 7'b0010011: begin
        if (fn3 == 3'd0)      op = (o == 7'b0110011 && fn7) ? 3'd2 : 3'd1;
        else if (fn3 == 3'd7) op = 3'd3;
        else if (fn3 == 3'd4) op = 3'd4;
        else                  op = 3'd0;
        if (o == 7'b0110011) exp_q.push_back(ent(4'd3, 1'b1, 2'b00, op));
        else                 exp_q.push_back(ent(4'd4, 1'b1, 2'b10, op));
        if (op == 3'd0) tr = 1'b1;
        else begin e = ent(4'd9, 1'b0, 2'b00, 3'd0); e.rw = 1'b1; exp_q.push_back(e); end
      end
      7'b0000011, 7'b0100011: begin
        exp_q.push_back(ent(4'd5, 1'b1, 2'b10, 3'd1));
        if (fn3 != 3'd3) tr = 1'b1;
        else if (o == 7'b0000011) begin
          repeat (mw) exp_q.push_back(ent(4'd6, 1'b1, 2'b10, 3'd1));
          e = ent(4'd7, 1'b0, 2'b00, 3'd0); e.rw = 1'b1; e.wb = 2'b01; exp_q.push_back(e);
        end else begin
          e = ent(4'd8, 1'b0, 2'b00, 3'd0); e.dw = 1'b1; exp_q.push_back(e);
        end
      end
      7'b1100011: begin
        taken = (fn3 == 3'd0 && z) || (fn3 == 3'd1 && !z);
        e = ent(4'd10, 1'b1, 2'b00, 3'd2); e.pcw = taken; e.ps = taken; exp_q.push_back(e);
        if (fn3 > 3'd1) tr = 1'b1;
      end
      7'b0110111: begin
        e = ent(4'd11, 1'b0, 2'b00, 3'd0); e.rw = 1'b1; e.wb = 2'b11; exp_q.push_back(e);
      end
      7'b1101111: begin
        e = ent(4'd12, 1'b0, 2'b00, 3'd0);
        e.rw = 1'b1; e.wb = 2'b10; e.pcw = 1'b1; e.ps = 1'b1; exp_q.push_back(e);
      end
      default: tr = 1'b1;
    endcase
    if (tr) repeat (20) begin
      e = ent(4'd13, 1'b0, 2'b00, 3'd0); e.ill = 1'b1; exp_q.push_back(e);
    end
    trapped = tr;
  endtask

  task automatic set_in(input int d, input logic [6:0] o, input logic [2:0] fn3,
                        input logic fn7, input logic z);
    opc[d] = o; f3[d] = fn3; f7[d] = fn7; zero[d] = z;
  endtask

  // Called at a falling edge with the DUT sitting in FETCH.
  task automatic run_instr(input int d, input logic [6:0] o, input logic [2:0] fn3,
                           input logic fn7, input logic z, output bit trapped, output int len);
    exp_t got;
    set_in(d, o, fn3, fn7, z);
    build(mw_of(d), o, fn3, fn7, z, trapped);
    len = trapped ? exp_q.size() - 20 : exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      got = observe(d);
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL trace dut%0d op=%b f3=%b step %0d: got %h want %h",
                 d, o, fn3, i, got, exp_q[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst_n[d] = 1'b0;
    #1;
    checks++;
    if (observe(d) !== ent(4'd0, 1'b0, 2'b01, 3'b001)) begin
      failures++;
      $display("FAIL reset_async dut%0d: got %h want %h", d, observe(d), ent(4'd0, 1'b0, 2'b01, 3'b001));
    end
    @(negedge clk);
    checks++;
    if (st[d] !== 4'd0 || ill[d] !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold dut%0d: state %0d illegal %b want 0 0", d, st[d], ill[d]);
    end
    rst_n[d] = 1'b1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      rst_n[d] = 1'b0;
    end
  endtask

  task automatic test_r_sub();
    bit tr; int len;
    do_reset(0);
    run_instr(0, 7'b0110011, 3'b000, 1'b1, 1'b0, tr, len);
    checks++;
    if (len !== 5 || st[0] !== 4'd0) begin
      failures++;
      $display("FAIL r_sub_len: len %0d state %0d want 5 0", len, st[0]);
    end
    rst_n[0] = 1'b0;
  endtask

  task automatic test_load_wait3();
    bit tr; int len;
    do_reset(1);
    run_instr(1, 7'b0000011, 3'b011, 1'b0, 1'b0, tr, len);
    checks++;
    if (len !== 10 || st[1] !== 4'd0) begin
      failures++;
      $display("FAIL load_len: len %0d state %0d want 10 0", len, st[1]);
    end
    run_instr(1, 7'b0100011, 3'b011, 1'b0, 1'b0, tr, len);
    rst_n[1] = 1'b0;
  endtask

  task automatic test_branch();
    bit tr; int len;
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      run_instr(d, 7'b1100011, 3'b001, 1'b0, 1'b0, tr, len);
      run_instr(d, 7'b1100011, 3'b001, 1'b0, 1'b1, tr, len);
      run_instr(d, 7'b1100011, 3'b000, 1'b0, 1'b1, tr, len);
      run_instr(d, 7'b1100011, 3'b000, 1'b0, 1'b0, tr, len);
      run_instr(d, 7'b0110111, 3'b101, 1'b0, 1'b0, tr, len);
      run_instr(d, 7'b1101111, 3'b010, 1'b1, 1'b0, tr, len);
      rst_n[d] = 1'b0;
    end
  endtask

  task automatic test_trap();
    bit tr; int len;
    do_reset(0);
    run_instr(0, 7'b1111111, 3'b000, 1'b0, 1'b0, tr, len);
    checks++;
    if (tr !== 1'b1 || ill[0] !== 1'b1) begin
      failures++;
      $display("FAIL trap_sticky: illegal %b want 1", ill[0]);
    end
    do_reset(0);
    run_instr(0, 7'b0010011, 3'b100, 1'b0, 1'b0, tr, len);
    rst_n[0] = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit tr; int len; int n;
    logic [3:0] target [2];
    target[0] = 4'd6;
    target[1] = 4'd1;
    for (int k = 0; k < 2; k++) begin
      do_reset(1);
      set_in(1, 7'b0000011, 3'b011, 1'b0, 1'b0);
      n = 0;
      while (st[1] !== target[k] && n < 20) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 20) begin
        failures++;
        $display("FAIL abort_reach: state %0d want %0d", st[1], target[k]);
      end
      if (k == 0) begin @(posedge clk); @(negedge clk); end
      #2;
      rst_n[1] = 1'b0;
      #1;
      checks++;
      if (st[1] !== 4'd0 || rw[1] !== 1'b0 || pcw[1] !== 1'b0 || irw[1] !== 1'b0) begin
        failures++;
        $display("FAIL abort_async: state %0d rw %b pcw %b irw %b want 0 0 0 0",
                 st[1], rw[1], pcw[1], irw[1]);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (st[1] !== 4'd0 || rw[1] !== 1'b0) begin
        failures++;
        $display("FAIL abort_hold: state %0d rw %b want 0 0", st[1], rw[1]);
      end
      rst_n[1] = 1'b1;
      run_instr(1, 7'b0110011, 3'b111, 1'b0, 1'b0, tr, len);
      rst_n[1] = 1'b0;
    end
  endtask

  task automatic test_random_back_to_back();
    bit tr; int len; int pick;
    logic [6:0] o; logic [2:0] fn3;
    logic [6:0] ops [7];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      for (int i = 0; i < 30; i++) begin
        pick = $urandom_range(0, 7);
        o = (pick == 7) ? 7'($urandom) : ops[pick];
        fn3 = 3'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          case (o)
            7'b0110011, 7'b0010011: fn3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4 + 3'(3 * $urandom_range(0, 1));
            7'b0000011, 7'b0100011: fn3 = 3'd3;
            7'b1100011:             fn3 = 3'($urandom_range(0, 1));
            default:                fn3 = fn3;
          endcase
        end
        run_instr(d, o, fn3, 1'($urandom), 1'($urandom), tr, len);
        if (tr) do_reset(d);
      end
      rst_n[d] = 1'b0;
    end
  endtask

  // Output exclusivity must hold in every cycle of every active instance.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] === 1'b1) begin
        checks++;
        if ((pcw[d] && irw[d] && st[d] != 4'd1) || (dw[d] && rw[d])) begin
          failures++;
          $display("FAIL exclusive dut%0d state %0d: pcw %b irw %b dw %b rw %b",
                   d, st[d], pcw[d], irw[d], dw[d], rw[d]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      set_in(d, 7'd0, 3'd0, 1'b0, 1'b0);
    end
    test_reset();
    test_r_sub();
    test_load_wait3();
    test_branch();
    test_trap();
    test_reset_abort();
    test_random_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_fsm.md
DECODE_CTRL_FSM -- requirements
Module: decode_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1: memory read latency in cycles (legal range 1..7), applied to both fetch and load.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous reset, active-low.
REQ-004 SHALL have port opcode, input, 7: instruction-register bits 6:0.
REQ-005 SHALL have port funct3, input, 3: instruction-register bits 14:12.
REQ-006 SHALL have port funct7_5, input, 1: instruction-register bit 30.
REQ-007 SHALL have port alu_zero, input, 1: ALU result-equals-zero flag.
REQ-008 SHALL have port pc_write, output, 1: PC register load enable.
REQ-009 SHALL have port ir_write, output, 1: instruction-register load enable.
REQ-010 SHALL have port dmem_wr, output, 1: data-memory write enable.
REQ-011 SHALL have port reg_write, output, 1: register-file write enable.
REQ-012 SHALL have port alu_src_a, output, 1: ALU operand A select (0 = PC, 1 = rs1).
REQ-013 SHALL have port alu_src_b, output, 2: ALU operand B select (00 = rs2, 01 = constant 4, 10 = immediate).
REQ-014 SHALL have port alu_op, output, 3: ALU selector (000 = pass A, 001 = add, 010 = sub, 011 = and, 100 = xor).
REQ-015 SHALL have port wb_sel, output, 2: write-back source (00 = ALU out, 01 = memory data, 10 = PC+4, 11 = immediate).
REQ-016 SHALL have port pc_src, output, 1: PC input select (0 = ALU result, 1 = branch/jump target).
REQ-017 SHALL have port state_out, output, 4: current-state code, for debug.
REQ-018 SHALL have port illegal, output, 1: sticky illegal-opcode flag.

Function
REQ-019 SHALL implement a Moore FSM; every output is a function of the state register (and of alu_zero in BRANCH only), with deasserted outputs = 0.
REQ-020 States and codes: FETCH 0, IF_WAIT 1, DECODE 2, EXEC_R 3, EXEC_I 4, ADDR 5, LD_WAIT 6, LD_WB 7, ST 8, ALU_WB 9, BRANCH 10, LUI 11, JAL 12, TRAP 13.
REQ-021 FETCH: alu_src_a = 0, alu_src_b = 01, alu_op = 001; wait counter loaded with MEM_WAIT-1; go to IF_WAIT.
REQ-022 IF_WAIT: decrement the counter each cycle; on the cycle the counter is 0, assert ir_write and pc_write (PC <- PC+4) once and go to DECODE.
REQ-023 DECODE dispatch by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> ADDR; 1100011 -> BRANCH; 0110111 -> LUI; 1101111 -> JAL; any other opcode -> TRAP.
REQ-024 EXEC_R: alu_src_a = 1, alu_src_b = 00; funct3 000 with funct7_5 = 0 -> add, 000 with funct7_5 = 1 -> sub, 111 -> and, 100 -> xor, other funct3 -> TRAP; otherwise go to ALU_WB.
REQ-025 EXEC_I: alu_src_a = 1, alu_src_b = 10; funct3 000 -> add, 111 -> and, 100 -> xor, other funct3 -> TRAP; otherwise go to ALU_WB.
REQ-026 ALU_WB: reg_write = 1, wb_sel = 00; go to FETCH.
REQ-027 ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 001; a load opcode with funct3 011 goes to LD_WAIT (counter loaded with MEM_WAIT-1); a store opcode with funct3 011 goes to ST; any other funct3 goes to TRAP.
REQ-028 LD_WAIT: hold the address controls, count as in IF_WAIT, then go to LD_WB; LD_WB: reg_write = 1, wb_sel = 01; go to FETCH.
REQ-029 ST: dmem_wr = 1 for exactly one cycle; go to FETCH.
REQ-030 BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 010; funct3 000 takes the branch when alu_zero = 1, funct3 001 takes it when alu_zero = 0; a taken branch asserts pc_write = 1 and pc_src = 1; other funct3 -> TRAP; otherwise go to FETCH.
REQ-031 LUI: reg_write = 1, wb_sel = 11; go to FETCH.
REQ-032 JAL: reg_write = 1, wb_sel = 10, pc_write = 1, pc_src = 1; go to FETCH.
REQ-033 TRAP: all enables 0; set illegal = 1; remain in TRAP until reset.
REQ-034 pc_write and ir_write SHALL never both be asserted in any state other than IF_WAIT.
REQ-035 dmem_wr and reg_write SHALL never be asserted in the same cycle.

Reset
REQ-036 When rst = 0, asynchronously: state = FETCH, counter = 0, illegal = 0, all outputs 0 except the FETCH Moore outputs.
REQ-037 Reset asserted mid-instruction (including during IF_WAIT, LD_WAIT or TRAP) SHALL abort it with no further enable pulses; the first FETCH follows the first rising clk edge after rst goes to 1.

Verification
REQ-038 MEM_WAIT = 1, opcode 0110011, funct3 000, funct7_5 = 1 -> state sequence 0,1,2,3,9,0; alu_op = 010 in EXEC_R; one reg_write pulse.
REQ-039 MEM_WAIT = 3, load opcode 0000011, funct3 011 -> IF_WAIT lasts 3 cycles, LD_WAIT lasts 3 cycles; wb_sel = 01 in LD_WB; 10 cycles per instruction.
REQ-040 Branch opcode 1100011, funct3 001 with alu_zero = 0 -> pc_write = 1 and pc_src = 1 in BRANCH; repeat with alu_zero = 1 -> pc_write = 0.
REQ-041 opcode 1111111 -> TRAP (13), illegal = 1 held for 20 cycles with no enables asserted; rst pulse -> illegal = 0 and state = 0.
REQ-042 rst asserted during LD_WAIT -> state_out = 0 immediately, no reg_write pulse; the next instruction fetches normally.
